// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64 control FSM: states, opcodes,
// ALU operation codes and trap causes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_ld;
        logic is_sd;
        logic is_beq;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classification of the IR opcode field into instruction classes.
module opcode_class_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  cls_o
);

    always_comb begin
        cls_o        = '0;
        cls_o.is_r   = (opcode_i == OP_R);
        cls_o.is_i   = (opcode_i == OP_I);
        cls_o.is_ld  = (opcode_i == OP_LD);
        cls_o.is_sd  = (opcode_i == OP_SD);
        cls_o.is_beq = (opcode_i == OP_BEQ);
        cls_o.illegal = !(cls_o.is_r | cls_o.is_i | cls_o.is_ld | cls_o.is_sd | cls_o.is_beq);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV64 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with
// instruction/data memories, counts retired instructions and traps on errors.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [1:0]        cause_q, cause_d;
    logic              active_q;
    logic              retire;
    logic              wait_last;
    op_class_t         cls;

    opcode_class_decode u_decode (
        .opcode_i (opcode),
        .cls_o    (cls)
    );

    // active_q keeps every output quiet in the cycle(s) the reset is being sampled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            active_q  <= 1'b1;
        end
    end

    // A ready arriving while wait_q is one short of TIMEOUT is still taken.
    assign wait_last = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;

        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (wait_last) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_IMEM_TO;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (cls.illegal) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_src = cls.is_i | cls.is_ld | cls.is_sd;
                    if (cls.is_r | cls.is_i) begin
                        alu_op  = ALUOP_FUNCT;
                        state_d = S_WB;
                    end else if (cls.is_ld | cls.is_sd) begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end else begin
                        alu_op   = ALUOP_SUB;
                        pc_write = zero;
                        pc_src   = zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                        wait_d   = '0;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = cls.is_sd;
                    if (dmem_ready) begin
                        if (cls.is_sd) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                            wait_d  = '0;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wait_last) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_DMEM_TO;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = cls.is_ld;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                    wait_d     = '0;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            endcase
        end

        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    assign instret = instret_q;

endmodule
